// File: rtl/rotation_tracker.sv
// rotation_tracker: receiver-side tracker for a rotating 8-bit one-hot pattern.
// It recovers the position and step direction of the set bit, locks onto a
// consistent rotation, and flags sequence breaks that occur while locked.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   valid_in       pattern_in is sampled this cycle
//   pattern_in     observed 8-bit pattern
//   position       bit index of the last accepted one-hot sample
//   direction      last step direction (1 = towards MSB, 0 = towards LSB)
//   locked         high while tracking a locked rotation
//   err            one-cycle pulse on a sequence break while locked
//   dir_flip       one-cycle pulse on a direction reversal while locked
//   step_count     accepted steps while locked, saturating at 255
//   err_count      number of err pulses, saturating at 255
module rotation_tracker #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [7:0] pattern_in,
  output logic [2:0] position,
  output logic       direction,
  output logic       locked,
  output logic       err,
  output logic       dir_flip,
  output logic [7:0] step_count,
  output logic [7:0] err_count
);

  localparam int unsigned RUN_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       ref_q, ref_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       position_q, position_d;
  logic             direction_q, direction_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             dir_flip_q, dir_flip_d;
  logic [7:0]       step_count_q, step_count_d;
  logic [7:0]       err_count_q, err_count_d;

  // Sample classification against the stored reference.
  logic       is_onehot;
  logic       is_hold;
  logic       is_left;
  logic       is_right;
  logic [2:0] cur_idx;

  always_comb begin
    is_onehot = (pattern_in != 8'h00) && ((pattern_in & (pattern_in - 8'd1)) == 8'h00);
    is_hold   = (pattern_in == ref_q);
    is_left   = (pattern_in == {ref_q[6:0], ref_q[7]});
    is_right  = (pattern_in == {ref_q[0], ref_q[7:1]});
    cur_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pattern_in[i]) cur_idx = 3'(i);
    end
  end

  // Next-state and output computation.
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    run_d        = run_q;
    position_d   = position_q;
    direction_d  = direction_q;
    err_d        = 1'b0;
    dir_flip_d   = 1'b0;
    step_count_d = step_count_q;
    err_count_d  = err_count_q;

    if (valid_in) begin
      unique case (state_q)
        IDLE: begin
          if (is_onehot) begin
            state_d    = ACQ;
            run_d      = '0;
            ref_d      = pattern_in;
            position_d = cur_idx;
          end
        end
        ACQ: begin
          if (!is_onehot) begin
            state_d = IDLE;
            run_d   = '0;
          end else if (is_hold) begin
            state_d = ACQ;
          end else if (is_left || is_right) begin
            // A first step after acquisition always counts toward the run.
            if (run_q == '0 || is_left == direction_q) run_d = RUN_W'(run_q + RUN_W'(1));
            else                                         run_d = RUN_W'(1);
            direction_d = is_left;
            ref_d       = pattern_in;
            position_d  = cur_idx;
            if (run_d == RUN_W'(LOCK_CNT)) state_d = LOCKED;
          end else begin
            run_d      = '0;
            ref_d      = pattern_in;
            position_d = cur_idx;
          end
        end
        LOCKED: begin
          if (!is_onehot) begin
            err_d       = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : 8'(err_count_q + 8'd1);
            state_d     = IDLE;
            run_d       = '0;
          end else if (is_hold) begin
            state_d = LOCKED;
          end else if (is_left || is_right) begin
            step_count_d = (step_count_q == 8'hFF) ? step_count_q : 8'(step_count_q + 8'd1);
            dir_flip_d   = (is_left != direction_q);
            direction_d  = is_left;
            ref_d        = pattern_in;
            position_d   = cur_idx;
          end else begin
            err_d       = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : 8'(err_count_q + 8'd1);
            state_d     = ACQ;
            run_d       = '0;
            ref_d       = pattern_in;
            position_d  = cur_idx;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end

    // locked reflects the state being entered so it moves with err.
    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ref_q        <= 8'h80;
      run_q        <= '0;
      position_q   <= 3'd7;
      direction_q  <= 1'b1;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      dir_flip_q   <= 1'b0;
      step_count_q <= 8'd0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      run_q        <= run_d;
      position_q   <= position_d;
      direction_q  <= direction_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      dir_flip_q   <= dir_flip_d;
      step_count_q <= step_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign position   = position_q;
  assign direction  = direction_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign dir_flip   = dir_flip_q;
  assign step_count = step_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_rotation_tracker.sv
// Testbench for rotation_tracker: a behavioural reference model pushes the
// expected outputs for every driven cycle into a scoreboard queue, a monitor
// pops and compares after each edge, and each scenario task also checks the
// key values it is about directly.
module tb_rotation_tracker;

  localparam int unsigned LOCK_CNT = 2;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [7:0] pattern_in;
  logic [2:0] position;
  logic       direction;
  logic       locked;
  logic       err;
  logic       dir_flip;
  logic [7:0] step_count;
  logic [7:0] err_count;

  rotation_tracker #(.LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pattern_in (pattern_in),
    .position   (position),
    .direction  (direction),
    .locked     (locked),
    .err        (err),
    .dir_flip   (dir_flip),
    .step_count (step_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pos;
    logic       dir;
    logic       lck;
    logic       er;
    logic       flp;
    logic [7:0] steps;
    logic [7:0] errs;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;

  // Reference model state.
  int         m_state;  // 0 idle, 1 acquiring, 2 locked
  logic [7:0] m_ref;
  int         m_run;
  logic [2:0] m_pos;
  logic       m_dir;
  logic       m_lck;
  logic       m_err;
  logic       m_flp;
  int         m_steps;
  int         m_errs;

  task automatic model(input bit r, input bit v, input logic [7:0] p);
    bit         oh, lft, rgt;
    logic [2:0] idx;
    if (r) begin
      m_state = 0; m_ref = 8'h80; m_run = 0; m_pos = 3'd7; m_dir = 1'b1;
      m_lck = 1'b0; m_err = 1'b0; m_flp = 1'b0; m_steps = 0; m_errs = 0;
      return;
    end
    m_err = 1'b0;
    m_flp = 1'b0;
    if (v) begin
      oh  = $countones(p) == 1;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) if (p[i]) idx = 3'(i);
      lft = (p == {m_ref[6:0], m_ref[7]});
      rgt = (p == {m_ref[0], m_ref[7:1]});
      if (m_state == 0) begin
        if (oh) begin m_state = 1; m_run = 0; m_ref = p; m_pos = idx; end
      end else if (!oh) begin
        if (m_state == 2) begin
          m_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
        m_state = 0; m_run = 0;
      end else if (p == m_ref) begin
        // stall
      end else if (lft || rgt) begin
        if (m_state == 1) begin
          if (m_run == 0 || lft == m_dir) m_run++; else m_run = 1;
          if (m_run == LOCK_CNT) m_state = 2;
        end else begin
          if (m_steps < 255) m_steps++;
          m_flp = (lft != m_dir);
        end
        m_dir = lft; m_ref = p; m_pos = idx;
      end else begin
        if (m_state == 2) begin
          m_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
        m_state = 1; m_run = 0; m_ref = p; m_pos = idx;
      end
    end
    m_lck = (m_state == 2);
  endtask

  // Drive one cycle at the falling edge, record the expectation, settle after the edge.
  task automatic apply(input bit r, input bit v, input logic [7:0] p);
    exp_t e;
    @(negedge clk);
    rst_n      = ~r;
    valid_in   = v;
    pattern_in = p;
    model(r, v, p);
    e.pos = m_pos; e.dir = m_dir; e.lck = m_lck; e.er = m_err; e.flp = m_flp;
    e.steps = 8'(m_steps); e.errs = 8'(m_errs);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every driven cycle produces one expectation.
  always @(posedge clk) begin
    exp_t e, a;
    #3;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a.pos = position; a.dir = direction; a.lck = locked; a.er = err; a.flp = dir_flip;
      a.steps = step_count; a.errs = err_count;
      tests_run++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got pos=%0d dir=%0b lck=%0b err=%0b flip=%0b steps=%0d errs=%0d, expected pos=%0d dir=%0b lck=%0b err=%0b flip=%0b steps=%0d errs=%0d",
                 $time, a.pos, a.dir, a.lck, a.er, a.flp, a.steps, a.errs,
                 e.pos, e.dir, e.lck, e.er, e.flp, e.steps, e.errs);
      end
    end
  end

  task automatic test_reset();
    apply(1'b1, 1'b1, 8'h10);
    apply(1'b1, 1'b1, 8'h10);
    tests_run++;
    if ({position, direction, locked, err, dir_flip, step_count, err_count} !== {3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset: got pos=%0d dir=%0b lck=%0b steps=%0d errs=%0d, expected pos=7 dir=1 lck=0 steps=0 errs=0",
               position, direction, locked, step_count, err_count);
    end
  endtask

  task automatic test_lock_left_wrap();
    apply(1'b0, 1'b1, 8'h80);
    apply(1'b0, 1'b1, 8'h01);
    tests_run++;
    if (locked !== 1'b0) begin failures++; $display("FAIL early_lock: got locked=%0b, expected 0", locked); end
    apply(1'b0, 1'b1, 8'h02);
    tests_run++;
    if ({locked, position, direction, step_count} !== {1'b1, 3'd1, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL lock_left: got lck=%0b pos=%0d dir=%0b steps=%0d, expected lck=1 pos=1 dir=1 steps=0",
               locked, position, direction, step_count);
    end
    apply(1'b0, 1'b1, 8'h04);
    tests_run++;
    if ({step_count, position} !== {8'd1, 3'd2}) begin
      failures++;
      $display("FAIL locked_step: got steps=%0d pos=%0d, expected steps=1 pos=2", step_count, position);
    end
  endtask

  task automatic test_reversal();
    apply(1'b0, 1'b1, 8'h02);
    tests_run++;
    if ({dir_flip, direction, locked, step_count} !== {1'b1, 1'b0, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL reversal: got flip=%0b dir=%0b lck=%0b steps=%0d, expected flip=1 dir=0 lck=1 steps=2",
               dir_flip, direction, locked, step_count);
    end
    apply(1'b0, 1'b1, 8'h02);
    tests_run++;
    if ({dir_flip, step_count, position, locked} !== {1'b0, 8'd2, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL hold: got flip=%0b steps=%0d pos=%0d lck=%0b, expected flip=0 steps=2 pos=1 lck=1",
               dir_flip, step_count, position, locked);
    end
  endtask

  task automatic test_jump();
    apply(1'b0, 1'b1, 8'h10);
    tests_run++;
    if ({err, err_count, locked, position} !== {1'b1, 8'd1, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL jump: got err=%0b errs=%0d lck=%0b pos=%0d, expected err=1 errs=1 lck=0 pos=4",
               err, err_count, locked, position);
    end
    apply(1'b0, 1'b1, 8'h08);
    tests_run++;
    if ({err, locked} !== 2'b00) begin
      failures++;
      $display("FAIL err_pulse: got err=%0b lck=%0b, expected err=0 lck=0", err, locked);
    end
    apply(1'b0, 1'b1, 8'h04);
    tests_run++;
    if ({locked, direction} !== 2'b10) begin
      failures++;
      $display("FAIL relock: got lck=%0b dir=%0b, expected lck=1 dir=0", locked, direction);
    end
  endtask

  task automatic test_gaps_and_bad();
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 8'(8'h5A + i));
    tests_run++;
    if ({locked, position, step_count, err} !== {1'b1, 3'd2, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL gap_hold: got lck=%0b pos=%0d steps=%0d err=%0b, expected lck=1 pos=2 steps=2 err=0",
               locked, position, step_count, err);
    end
    apply(1'b0, 1'b1, 8'h03);
    tests_run++;
    if ({err, err_count, locked} !== {1'b1, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL bad_sample: got err=%0b errs=%0d lck=%0b, expected err=1 errs=2 lck=0", err, err_count, locked);
    end
    apply(1'b0, 1'b1, 8'h00);
    tests_run++;
    if ({err, locked, position, err_count} !== {1'b0, 1'b0, 3'd2, 8'd2}) begin
      failures++;
      $display("FAIL zero_in_idle: got err=%0b lck=%0b pos=%0d errs=%0d, expected err=0 lck=0 pos=2 errs=2",
               err, locked, position, err_count);
    end
    // ACQ must not flag errors on a jump.
    apply(1'b0, 1'b1, 8'h01);
    apply(1'b0, 1'b1, 8'h40);
    tests_run++;
    if ({err, err_count, position} !== {1'b0, 8'd2, 3'd6}) begin
      failures++;
      $display("FAIL acq_jump: got err=%0b errs=%0d pos=%0d, expected err=0 errs=2 pos=6", err, err_count, position);
    end
  endtask

  task automatic test_midlock_reset();
    apply(1'b0, 1'b1, 8'h20);
    apply(1'b0, 1'b1, 8'h10);
    tests_run++;
    if (locked !== 1'b1) begin failures++; $display("FAIL lock_before_reset: got lck=%0b, expected 1", locked); end
    apply(1'b1, 1'b1, 8'h08);
    tests_run++;
    if ({position, direction, locked, err, dir_flip, step_count, err_count} !== {3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL midlock_reset: got pos=%0d dir=%0b lck=%0b steps=%0d errs=%0d, expected pos=7 dir=1 lck=0 steps=0 errs=0",
               position, direction, locked, step_count, err_count);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] p;
    p = 8'h80;
    for (int i = 0; i < 303; i++) begin
      apply(1'b0, 1'b1, p);
      p = {p[6:0], p[7]};
      if (i == 2) begin
        tests_run++;
        if (locked !== 1'b1) begin failures++; $display("FAIL sat_lock: got lck=%0b, expected 1", locked); end
      end
    end
    tests_run++;
    if ({step_count, locked} !== {8'd255, 1'b1}) begin
      failures++;
      $display("FAIL saturation: got steps=%0d lck=%0b, expected steps=255 lck=1", step_count, locked);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    pattern_in = 8'h00;
    test_reset();
    test_lock_left_wrap();
    test_reversal();
    test_jump();
    test_gaps_and_bad();
    test_midlock_reset();
    test_saturation();
    @(posedge clk);
    #5;
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
